// File: rtl/addsub_pipe_param.sv
// addsub_pipe_param
// Pipelined WIDTH-bit adder/subtractor. Each stage resolves one CHUNK-bit
// slice with a ripple of full adders and hands its carry to the next stage.
// The unresolved operand slices travel forward with the beat. A single global
// advance signal moves or holds the whole pipeline, so bubbles are kept and
// a stalled output stays stable. Subtraction inverts B at the input and
// forces the carry-in to 1.
module addsub_pipe_param #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int STAGES = WIDTH / CHUNK;

  // Per-stage registered state
  logic             vld_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];

  // Flags of the beat sitting in the last stage
  logic ovf_q;
  logic zero_q;
  logic neg_q;

  // Holds in_ready low until the first clock edge after reset release
  logic rdy_en_q;

  // Stage inputs (what each stage sees from the one before it)
  logic             v_src [STAGES];
  logic [WIDTH-1:0] a_src [STAGES];
  logic [WIDTH-1:0] b_src [STAGES];
  logic [WIDTH-1:0] s_src [STAGES];
  logic             c_src [STAGES];

  // Stage results
  logic [WIDTH-1:0] s_d [STAGES];
  logic             c_d [STAGES];

  logic cy;
  logic msb_cin;
  logic ovf_d;
  logic zero_d;
  logic neg_d;

  logic advance;
  logic accept;

  assign advance   = !vld_q[STAGES-1] || out_ready;
  assign in_ready  = rdy_en_q && advance;
  assign accept    = in_valid && in_ready;

  assign out_valid = vld_q[STAGES-1];
  assign result    = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

  // Route the conditioned input beat into stage 0 and each stage's registers
  // into the following stage.
  always_comb begin
    v_src[0] = accept;
    a_src[0] = a;
    b_src[0] = b ^ {WIDTH{sub}};
    s_src[0] = '0;
    c_src[0] = sub | cin;
    for (int k = 1; k < STAGES; k++) begin
      v_src[k] = vld_q[k-1];
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = s_q[k-1];
      c_src[k] = c_q[k-1];
    end
  end

  // Ripple-carry resolve of slice k in stage k; also capture the carry into
  // the MSB, which only the last stage sees, for the overflow flag.
  always_comb begin
    cy      = 1'b0;
    msb_cin = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      s_d[k] = s_src[k];
      cy     = c_src[k];
      for (int i = 0; i < CHUNK; i++) begin
        s_d[k][k*CHUNK+i] = a_src[k][k*CHUNK+i] ^ b_src[k][k*CHUNK+i] ^ cy;
        if (k*CHUNK+i == WIDTH-1) begin
          msb_cin = cy;
        end
        cy = (a_src[k][k*CHUNK+i] & b_src[k][k*CHUNK+i]) |
             (cy & (a_src[k][k*CHUNK+i] ^ b_src[k][k*CHUNK+i]));
      end
      c_d[k] = cy;
    end
  end

  // Result flags for the beat that is entering the last stage
  always_comb begin
    ovf_d  = c_d[STAGES-1] ^ msb_cin;
    zero_d = ~|s_d[STAGES-1];
    neg_d  = s_d[STAGES-1][WIDTH-1];
  end

  // Pipeline registers: shift all stages together on advance, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
      end
    end else begin
      rdy_en_q <= 1'b1;
      if (advance) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
        neg_q  <= neg_d;
        for (int k = 0; k < STAGES; k++) begin
          vld_q[k] <= v_src[k];
          a_q[k]   <= a_src[k];
          b_q[k]   <= b_src[k];
          s_q[k]   <= s_d[k];
          c_q[k]   <= c_d[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_addsub_pipe_param.sv
// Bench for addsub_pipe_param: three instances (8/8, 16/4, 32/4) exercised
// one after another against an arithmetic reference model.
module tb_addsub_pipe_param;

  localparam int WD [3] = '{8, 16, 32};
  localparam int LT [3] = '{1, 4, 8};

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        o;
    logic        z;
    logic        n;
    int          acc;
    int          st;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv   [3];
  logic        ir   [3];
  logic        ov   [3];
  logic        ordy [3];
  logic        sb   [3];
  logic        ci   [3];
  logic [31:0] a_s  [3];
  logic [31:0] b_s  [3];
  logic        co   [3];
  logic        of   [3];
  logic        zr   [3];
  logic        ng   [3];
  logic [7:0]  r0;
  logic [15:0] r1;
  logic [31:0] r2;

  int   nvec = 0;
  int   nmis = 0;
  int   cyc = 0;
  int   stalls = 0;
  exp_t q[$];
  logic        stl_prev = 1'b0;
  logic [31:0] sv_res;
  logic [3:0]  sv_flg;

  addsub_pipe_param #(.WIDTH(8), .CHUNK(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_s[0][7:0]), .b(b_s[0][7:0]), .sub(sb[0]), .cin(ci[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .result(r0),
    .cout(co[0]), .ovf(of[0]), .zero(zr[0]), .neg(ng[0]));

  addsub_pipe_param #(.WIDTH(16), .CHUNK(4)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_s[1][15:0]), .b(b_s[1][15:0]), .sub(sb[1]), .cin(ci[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .result(r1),
    .cout(co[1]), .ovf(of[1]), .zero(zr[1]), .neg(ng[1]));

  addsub_pipe_param #(.WIDTH(32), .CHUNK(4)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_s[2]), .b(b_s[2]), .sub(sb[2]), .cin(ci[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .result(r2),
    .cout(co[2]), .ovf(of[2]), .zero(zr[2]), .neg(ng[2]));

  function automatic logic [31:0] res_of(int d);
    case (d)
      0:       return {24'b0, r0};
      1:       return {16'b0, r1};
      default: return r2;
    endcase
  endfunction

  function automatic logic [3:0] flg_of(int d);
    return {co[d], of[d], zr[d], ng[d]};
  endfunction

  // Reference: plain unsigned and signed arithmetic on the W-bit operands
  function automatic exp_t model(int w, logic [31:0] av, logic [31:0] bv,
                                 logic s, logic c_in);
    exp_t e;
    longint unsigned m, ua, ub, full, half;
    longint sa, sbv, sr, hs;
    m    = (64'd1 << w) - 64'd1;
    half = 64'd1 << (w - 1);
    hs   = longint'(half);
    ua   = {32'b0, av} & m;
    ub   = {32'b0, bv} & m;
    sa   = (ua >= half) ? longint'(ua) - 2 * hs : longint'(ua);
    sbv  = (ub >= half) ? longint'(ub) - 2 * hs : longint'(ub);
    if (s) begin
      full = ua - ub;
      e.c  = (ua >= ub);
      sr   = sa - sbv;
    end else begin
      full = ua + ub + {63'b0, c_in};
      e.c  = ((full >> w) & 64'd1) != 0;
      sr   = sa + sbv + longint'({63'b0, c_in});
    end
    e.res = 32'(full & m);
    e.o   = (sr >= hs) || (sr < -hs);
    e.z   = (e.res == 32'd0);
    e.n   = e.res[w-1];
    e.acc = 0;
    e.st  = 0;
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp_v);
    nvec++;
    assert (got === exp_v) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp_v);
    end
  endtask

  // One clock: sample at the falling edge, score handshakes, then return
  // just after the rising edge so the caller can drive the next inputs.
  task automatic cycle(input int d, output bit acc);
    exp_t e;
    acc = 1'b0;
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      chk("in_ready_rule", 32'(ir[d]), 32'(!ov[d] || ordy[d]));
      if (stl_prev) begin
        chk("stall_hold_result", res_of(d), sv_res);
        chk("stall_hold_flags", 32'(flg_of(d)), 32'(sv_flg));
      end
      stl_prev = ov[d] && !ordy[d];
      if (stl_prev) begin
        sv_res = res_of(d);
        sv_flg = flg_of(d);
        stalls++;
      end
      if (ov[d] && ordy[d]) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 32'(ov[d]), 32'd0);
        end else begin
          e = q.pop_front();
          chk("result", res_of(d), e.res);
          chk("cout", 32'(co[d]), 32'(e.c));
          chk("ovf", 32'(of[d]), 32'(e.o));
          chk("zero", 32'(zr[d]), 32'(e.z));
          chk("neg", 32'(ng[d]), 32'(e.n));
          chk("latency", 32'(cyc - e.acc), 32'(LT[d] + stalls - e.st));
        end
      end
      if (iv[d] && ir[d]) begin
        acc = 1'b1;
        e = model(WD[d], a_s[d], b_s[d], sb[d], ci[d]);
        e.acc = cyc;
        e.st  = stalls;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(int d, logic [31:0] av, logic [31:0] bv, logic s, logic c_in);
    bit done;
    done = 1'b0;
    iv[d] = 1'b1; a_s[d] = av; b_s[d] = bv; sb[d] = s; ci[d] = c_in;
    for (int t = 0; t < 40 && !done; t++) cycle(d, done);
    chk("send_accepted", 32'(done), 32'd1);
    iv[d] = 1'b0;
  endtask

  task automatic drain(int d);
    bit x;
    iv[d] = 1'b0;
    for (int t = 0; t < 60 && q.size() > 0; t++) cycle(d, x);
    chk("drain_empty", 32'(q.size()), 32'd0);
    for (int t = 0; t < 3; t++) cycle(d, x);
  endtask

  task automatic check_reset_outputs(int d, string tag);
    chk({tag, "_out_valid"}, 32'(ov[d]), 32'd0);
    chk({tag, "_result"}, res_of(d), 32'd0);
    chk({tag, "_flags"}, 32'(flg_of(d)), 32'd0);
  endtask

  task automatic release_reset(int d);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("in_ready_after_reset", 32'(ir[d]), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic run(int d);
    logic [31:0] mask, top;
    int  sent, stall_ctr;
    bit  acc, need_new;
    mask = (WD[d] == 32) ? 32'hFFFF_FFFF : ((32'd1 << WD[d]) - 32'd1);
    top  = 32'd1 << (WD[d] - 1);
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b1;
    end

    rst_n = 1'b0;
    q.delete(); stl_prev = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs(d, "reset");
    @(posedge clk); #1;
    release_reset(d);

    send(d, 32'h1234, 32'h0FCD, 1'b0, 1'b0);
    drain(d);
    send(d, 32'h0005, 32'h0007, 1'b1, 1'b0);
    send(d, top, 32'h0001, 1'b1, 1'b1);
    drain(d);
    send(d, mask, 32'h0000, 1'b0, 1'b1);
    send(d, top - 32'd1, 32'h0001, 1'b0, 1'b0);
    drain(d);

    sent = 0; stall_ctr = -1; need_new = 1'b1;
    for (int t = 0; t < 300 && (sent < 8 || q.size() > 0); t++) begin
      if (sent < 8) begin
        if (need_new) begin
          a_s[d] = $urandom; b_s[d] = $urandom;
          sb[d] = 1'($urandom_range(0, 1)); ci[d] = 1'($urandom_range(0, 1));
        end
        iv[d] = 1'b1;
      end else begin
        iv[d] = 1'b0;
      end
      ordy[d] = !(stall_ctr > 0);
      cycle(d, acc);
      need_new = acc;
      if (acc) sent++;
      if (stall_ctr > 0) stall_ctr--;
      if (stall_ctr == -1 && ov[d]) stall_ctr = 3;
    end
    chk("stream_sent", 32'(sent), 32'd8);
    chk("stream_stalled", 32'(stall_ctr), 32'd0);
    ordy[d] = 1'b1;
    drain(d);

    send(d, $urandom, $urandom, 1'b0, 1'b0);
    send(d, $urandom, $urandom, 1'b1, 1'b0);
    send(d, $urandom, $urandom, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(d, "async_reset");
    q.delete(); stl_prev = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset_outputs(d, "reset_hold");
    release_reset(d);
    send(d, 32'h00FF, 32'h0001, 1'b0, 1'b0);
    drain(d);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b1; sb[k] = 1'b0; ci[k] = 1'b0;
      a_s[k] = '0; b_s[k] = '0;
    end
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) run(d);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
